// File: rtl/cos_range_reduce.sv
// -----------------------------------------------------------------------------
// cos_range_reduce
//
// Purpose:
//   Range reduction front end for a cosine core. It takes an unsigned Q4.16
//   angle and folds it into [0, pi/4] (Q0.16). It also reports how the
//   downstream core should use the reduced angle:
//     sinSel : evaluate sin(xBus) instead of cos(xBus)
//     negate : negate the downstream result
//
//   Sequence: IDLE -> WRAP -> FOLD1 -> FOLD2 -> FOLD3 -> DONE -> IDLE
//     WRAP  : remove whole turns (r -= 2pi while r >= 2pi)
//     FOLD1 : cos(x) = cos(2pi - x)            when x > pi
//     FOLD2 : cos(x) = -cos(pi - x)            when x > pi/2
//     FOLD3 : cos(x) = sin(pi/2 - x)           when x > pi/4
//
// Configuration:
//   COS_RANGE_REDUCE_FAST_WRAP_EN - when defined, WRAP removes up to two turns
//   in a single cycle, so latency is a fixed 4 edges. When undefined, WRAP
//   removes one turn per cycle and latency is k+4 edges (k = whole turns).
//
// Ports:
//   clk      in   clock, rising edge active
//   rst      in   asynchronous active-high reset
//   start    in   request to reduce angleBus (accepted in IDLE or DONE)
//   angleBus in   [19:0] unsigned Q4.16 angle in radians
//   xBus     out  [15:0] reduced angle, unsigned Q0.16, 0..pi/4
//   sinSel   out  downstream evaluates sin instead of cos
//   negate   out  downstream result is negated
//   busy     out  high in WRAP/FOLD1/FOLD2/FOLD3
//   done     out  one-cycle pulse: xBus/sinSel/negate are valid
// -----------------------------------------------------------------------------
module cos_range_reduce (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [19:0] angleBus,
    output logic [15:0] xBus,
    output logic        sinSel,
    output logic        negate,
    output logic        busy,
    output logic        done
);

    localparam logic [19:0] TWO_PI  = 20'd411775;
    localparam logic [19:0] PI      = 20'd205887;
    localparam logic [19:0] HALF_PI = 20'd102944;
    localparam logic [19:0] QTR_PI  = 20'd51472;
`ifdef COS_RANGE_REDUCE_FAST_WRAP_EN
    localparam logic [19:0] FOUR_PI = 20'd823550;
`endif

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRAP  = 3'd1,
        FOLD1 = 3'd2,
        FOLD2 = 3'd3,
        FOLD3 = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t      state, state_nxt;
    logic [19:0] r, r_nxt;
    logic [15:0] xbus_nxt;
    logic        sinsel_nxt;
    logic        negate_nxt;
    logic        done_nxt;

    // Next-state and datapath decisions
    always_comb begin
        state_nxt  = state;
        r_nxt      = r;
        xbus_nxt   = xBus;
        sinsel_nxt = sinSel;
        negate_nxt = negate;
        done_nxt   = 1'b0;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    r_nxt      = angleBus;
                    sinsel_nxt = 1'b0;
                    negate_nxt = 1'b0;
                    state_nxt  = WRAP;
                end else begin
                    state_nxt  = IDLE;
                end
            end

            WRAP: begin
`ifdef COS_RANGE_REDUCE_FAST_WRAP_EN
                // Max input minus 4pi is already below 2pi, so at most one
                // of the two subtractions ever applies.
                if (r >= FOUR_PI) begin
                    r_nxt = r - FOUR_PI;
                end else if (r >= TWO_PI) begin
                    r_nxt = r - TWO_PI;
                end
                state_nxt = FOLD1;
`else
                // One turn removed per cycle; stay here until below 2pi.
                if (r >= TWO_PI) begin
                    r_nxt = r - TWO_PI;
                end else begin
                    state_nxt = FOLD1;
                end
`endif
            end

            FOLD1: begin
                if (r > PI) begin
                    r_nxt = TWO_PI - r;
                end
                state_nxt = FOLD2;
            end

            FOLD2: begin
                if (r > HALF_PI) begin
                    r_nxt      = PI - r;
                    negate_nxt = 1'b1;
                end
                state_nxt = FOLD3;
            end

            FOLD3: begin
                // Strict compare: exactly pi/4 stays on the cos path.
                if (r > QTR_PI) begin
                    r_nxt      = HALF_PI - r;
                    sinsel_nxt = 1'b1;
                end
                // Result is registered here so it is valid while in DONE;
                // r_nxt <= pi/4 so the upper four bits are zero.
                xbus_nxt  = r_nxt[15:0];
                done_nxt  = 1'b1;
                state_nxt = DONE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            r      <= 20'd0;
            xBus   <= 16'd0;
            sinSel <= 1'b0;
            negate <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_nxt;
            r      <= r_nxt;
            xBus   <= xbus_nxt;
            sinSel <= sinsel_nxt;
            negate <= negate_nxt;
            done   <= done_nxt;
        end
    end

    assign busy = (state == WRAP) || (state == FOLD1) ||
                  (state == FOLD2) || (state == FOLD3);

endmodule

// File: tb/tb_cos_range_reduce.sv
// -----------------------------------------------------------------------------
// tb_cos_range_reduce
//
// Directed testbench for cos_range_reduce. Expected results are hand-computed
// from the Q4.16 constants 2pi=411775, pi=205887, pi/2=102944, pi/4=51472.
// Latency expectations follow COS_RANGE_REDUCE_FAST_WRAP_EN if defined.
// -----------------------------------------------------------------------------
module tb_cos_range_reduce;

    logic        clk;
    logic        rst;
    logic        start;
    logic [19:0] angleBus;
    logic [15:0] xBus;
    logic        sinSel;
    logic        negate;
    logic        busy;
    logic        done;

    int n_assert;
    int n_fail;

    cos_range_reduce dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .angleBus (angleBus),
        .xBus     (xBus),
        .sinSel   (sinSel),
        .negate   (negate),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_latency(input int k);
`ifdef COS_RANGE_REDUCE_FAST_WRAP_EN
        return 4;
`else
        return 4 + k;
`endif
    endfunction

    // Issue one reduction and check latency, results, busy and pulse width.
    task automatic run(input string tag, input logic [19:0] a, input logic [15:0] ex,
                       input logic es, input logic en, input int k);
        int lat;
        @(negedge clk);
        angleBus = a;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
        end
        chk({tag, "_lat"},    lat, exp_latency(k));
        chk({tag, "_x"},      {16'd0, xBus}, {16'd0, ex});
        chk({tag, "_sin"},    {31'd0, sinSel}, {31'd0, es});
        chk({tag, "_neg"},    {31'd0, negate}, {31'd0, en});
        chk({tag, "_busy0"},  {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        chk({tag, "_pulse"},  {31'd0, done}, 32'd0);
        chk({tag, "_hold"},   {16'd0, xBus}, {16'd0, ex});
    endtask

    initial begin
        int ndone;
        int lat;
        n_assert = 0;
        n_fail   = 0;
        start    = 1'b0;
        angleBus = 20'd0;
        rst      = 1'b1;
        #1;
        chk("rst_x",    {16'd0, xBus}, 32'd0);
        chk("rst_sin",  {31'd0, sinSel}, 32'd0);
        chk("rst_neg",  {31'd0, negate}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        run("zero",   20'h00000, 16'd0,     1'b0, 1'b0, 0);
        run("one",    20'h10000, 16'd37408, 1'b1, 1'b0, 0);
        run("two",    20'h20000, 16'd28129, 1'b1, 1'b1, 0);
        run("three5", 20'h38000, 16'd23488, 1'b0, 1'b1, 0);
        run("eight",  20'h80000, 16'd9570,  1'b1, 1'b1, 1);
        run("max",    20'hFFFFF, 16'd19137, 1'b0, 1'b1, 2);
        run("twopi",  20'd411775, 16'd0,    1'b0, 1'b0, 1);
        run("pi",     20'd205887, 16'd0,    1'b0, 1'b1, 0);
        run("qtrp1",  20'd51473, 16'd51471, 1'b1, 1'b0, 0);

        // Exactly pi/4, with a second start during busy that must be ignored.
        @(negedge clk);
        angleBus = 20'd51472;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        angleBus = 20'h10000;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("ign_busy", {31'd0, busy}, 32'd1);
        lat = 0;
        for (int i = 2; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
        end
        chk("ign_lat", lat, 4);
        chk("ign_x",   {16'd0, xBus}, 32'd51472);
        chk("ign_sin", {31'd0, sinSel}, 32'd0);
        chk("ign_neg", {31'd0, negate}, 32'd0);
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        chk("ign_extra_done", ndone, 0);

        // Reset while in FOLD2 aborts the operation.
        @(negedge clk);
        angleBus = 20'h20000;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("mid_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_x",    {16'd0, xBus}, 32'd0);
        chk("mid_sin",  {31'd0, sinSel}, 32'd0);
        chk("mid_neg",  {31'd0, negate}, 32'd0);
        chk("mid_busy0", {31'd0, busy}, 32'd0);
        chk("mid_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        chk("mid_no_done", ndone, 0);

        run("after_rst", 20'h38000, 16'd23488, 1'b0, 1'b1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
